// File: rtl/mem_if_pkg.sv
// Shared definitions for the oe/we strobe memory interface: responder and
// controller state encodings plus default bus widths.
package mem_if_pkg;

  localparam int ADDR_W_DEF = 4;
  localparam int DATA_W_DEF = 8;
  localparam int CNT_W      = 4;

  typedef enum logic [2:0] {
    RSP_IDLE    = 3'd0,
    RSP_RD_WAIT = 3'd1,
    RSP_RD_DATA = 3'd2,
    RSP_WR_WAIT = 3'd3,
    RSP_WR_DONE = 3'd4,
    RSP_ERR     = 3'd5
  } rsp_state_e;

  // Encodings of the controller FSM that drives this interface.
  typedef enum logic [1:0] {
    CTL_IDLE  = 2'd0,
    CTL_CHKRW = 2'd1,
    CTL_READ  = 2'd2,
    CTL_WRITE = 2'd3
  } ctl_state_e;

endpackage

// File: rtl/mem_responder_if.sv
// Strobe bus between a memory controller (master) and the responder (slave).
interface mem_responder_if #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 8
) ();

  logic              oe;
  logic              we;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic [DATA_W-1:0] rdata;
  logic              rdata_valid;
  logic              wr_ack;
  logic              busy;
  logic              proto_err;
  logic [2:0]        state;

  modport master (
    output oe, we, addr, wdata,
    input  rdata, rdata_valid, wr_ack, busy, proto_err, state
  );

  modport slave (
    input  oe, we, addr, wdata,
    output rdata, rdata_valid, wr_ack, busy, proto_err, state
  );

endinterface

// File: rtl/mem_responder_ram.sv
// DEPTH x DATA_W synchronous array: one write port, one registered read port.
// Array contents are never reset; only the read register is.
module mem_responder_ram #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data
);

  localparam int DEPTH = 2 ** ADDR_W;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [DATA_W-1:0] rd_data_q;

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_data_q <= '0;
    end else if (rd_en) begin
      rd_data_q <= mem[rd_addr];
    end
  end

  assign rd_data = rd_data_q;

endmodule

// File: rtl/mem_responder.sv
// Memory-side responder: decodes oe/we level strobes into array accesses,
// inserting WAIT_STATES wait cycles before returning read data or a write ack.
module mem_responder
  import mem_if_pkg::*;
#(
  parameter int ADDR_W      = ADDR_W_DEF,
  parameter int DATA_W      = DATA_W_DEF,
  parameter int WAIT_STATES = 2
) (
  input  logic            clk,
  input  logic            reset,
  mem_responder_if.slave  bus
);

  localparam logic [CNT_W-1:0] WAIT_CNT = CNT_W'(WAIT_STATES);

  rsp_state_e        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              oe_q, we_q;
  logic              oe_rise, we_rise;
  logic              ram_wr_en, ram_rd_en;
  logic [DATA_W-1:0] ram_rd_data;

  assign oe_rise = bus.oe & ~oe_q;
  assign we_rise = bus.we & ~we_q;

  // Edge-detect registers follow the strobes even during reset, so a strobe
  // held high across reset is not mistaken for a fresh rise on release.
  always_ff @(posedge clk) begin
    oe_q    <= bus.oe;
    we_q    <= bus.we;
    addr_q  <= addr_d;
    wdata_q <= wdata_d;
    if (reset) begin
      state_q <= RSP_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    ram_wr_en = 1'b0;
    ram_rd_en = 1'b0;
    case (state_q)
      RSP_IDLE: begin
        if (bus.oe && bus.we) begin
          state_d = RSP_ERR;
        end else if (oe_rise) begin
          state_d = RSP_RD_WAIT;
          addr_d  = bus.addr;
          cnt_d   = WAIT_CNT;
        end else if (we_rise) begin
          state_d = RSP_WR_WAIT;
          addr_d  = bus.addr;
          wdata_d = bus.wdata;
          cnt_d   = WAIT_CNT;
        end
      end
      RSP_RD_WAIT: begin
        if (we_rise) begin
          state_d = RSP_ERR;
        end else if (!bus.oe) begin
          state_d = RSP_IDLE;
        end else if (cnt_q != '0) begin
          cnt_d = cnt_q - 1'b1;
        end else begin
          state_d   = RSP_RD_DATA;
          ram_rd_en = 1'b1;
        end
      end
      RSP_RD_DATA: begin
        if (we_rise) begin
          state_d = RSP_ERR;
        end else if (!bus.oe) begin
          state_d = RSP_IDLE;
        end
      end
      RSP_WR_WAIT: begin
        // A conflicting read or a dropped strobe must leave the array untouched.
        if (oe_rise) begin
          state_d = RSP_ERR;
        end else if (!bus.we) begin
          state_d = RSP_IDLE;
        end else if (cnt_q != '0) begin
          cnt_d = cnt_q - 1'b1;
        end else begin
          state_d   = RSP_WR_DONE;
          ram_wr_en = 1'b1;
        end
      end
      RSP_WR_DONE: begin
        if (oe_rise) begin
          state_d = RSP_ERR;
        end else if (!bus.we) begin
          state_d = RSP_IDLE;
        end
      end
      RSP_ERR: begin
        if (!bus.oe && !bus.we) begin
          state_d = RSP_IDLE;
        end
      end
      default: state_d = RSP_IDLE;
    endcase
  end

  mem_responder_ram #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_ram (
    .clk     (clk),
    .rst     (reset),
    .wr_en   (ram_wr_en),
    .wr_addr (addr_q),
    .wr_data (wdata_q),
    .rd_en   (ram_rd_en),
    .rd_addr (addr_q),
    .rd_data (ram_rd_data)
  );

  assign bus.rdata       = ram_rd_data;
  assign bus.rdata_valid = (state_q == RSP_RD_DATA);
  assign bus.wr_ack      = (state_q == RSP_WR_DONE);
  assign bus.busy        = (state_q == RSP_RD_WAIT) || (state_q == RSP_WR_WAIT);
  assign bus.proto_err   = (state_q == RSP_ERR);
  assign bus.state       = state_q;

endmodule
